// File: rtl/est_pkg.sv
// Shared types and helpers for the streaming W^T*Z estimator.
// Holds the FSM state enum, clog2, accumulator width and saturation clamp.
package est_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } est_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int dim);
    return 2 * dw + clog2(dim);
  endfunction

  // Clamp a sign-extended value into the signed dw-bit range.
  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/est_mac_lane.sv
// One signed MAC lane with one accumulator slot per pass.
// Ports: clk/rstn, en step, clr, mask, sel slot, w/z operands, acc slots.
module est_mac_lane
  import est_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 34,
  parameter int PASSES = 1,
  parameter int PW     = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    mask,
  input  logic [PW-1:0]           sel,
  input  logic signed [DW-1:0]    w,
  input  logic signed [DW-1:0]    z,
  output logic [PASSES*AW-1:0]    acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_q [PASSES];

  assign prod = w * z;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PASSES; p++) acc_q[p] <= '0;
    end else if (clr) begin
      for (int p = 0; p < PASSES; p++) acc_q[p] <= '0;
    end else if (en && !mask) begin
      for (int p = 0; p < PASSES; p++) begin
        if (sel == PW'(p)) acc_q[p] <= acc_q[p] + AW'(prod);
      end
    end
  end

  for (genvar p = 0; p < PASSES; p++) begin : g_out
    assign acc[p*AW +: AW] = acc_q[p];
  end

endmodule

// File: rtl/est_stream_mac.sv
// Streaming S = W^T*Z with LANES MACs, rescale and saturate.
// Ports: en, w_load/w_in, z_vld/z_rdy/z_in, s_vld/s_rdy/s_out, sat_flag, sample_cnt.
// EST_ROUND_EN selects round-half-up rescale instead of floor.
module est_stream_mac
  import est_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 3,
  parameter int LANES      = 3,
  parameter int FRAC_BITS  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             en,
  input  logic                             w_load,
  input  logic [DATA_WIDTH*DIM*DIM-1:0]    w_in,
  input  logic                             z_vld,
  output logic                             z_rdy,
  input  logic [DATA_WIDTH*DIM-1:0]        z_in,
  output logic                             s_vld,
  input  logic                             s_rdy,
  output logic [DATA_WIDTH*DIM-1:0]        s_out,
  output logic                             sat_flag,
  output logic [CNT_WIDTH-1:0]             sample_cnt
);

  localparam int DW     = DATA_WIDTH;
  localparam int PASSES = (DIM + LANES - 1) / LANES;
  localparam int AW     = acc_width(DW, DIM);
  localparam int PW     = clog2(PASSES + 1);
  localparam int RW     = clog2(DIM + 1);
`ifdef EST_ROUND_EN
  localparam longint BIAS =
    (FRAC_BITS > 0) ? (64'sd1 <<< (FRAC_BITS > 0 ? FRAC_BITS - 1 : 0)) : 0;
`endif

  est_state_t                  state;
  logic [DW*DIM*DIM-1:0]       w_q;
  logic [DW*DIM-1:0]           z_q;
  logic [RW-1:0]               row;
  logic [PW-1:0]               pass;
  logic                        done;
  logic                        mac_en;
  logic                        accept;
  logic [DW-1:0]               z_cur;
  logic [PASSES*AW-1:0]        acc_flat [LANES];
  logic signed [63:0]          clamped [DIM];
  logic signed [63:0]          scaled [DIM];
  logic [DW*DIM-1:0]           s_nxt;
  logic                        sat_nxt;

  // pass reaching PASSES means every row/pass step has been issued
  assign done   = (pass == PW'(PASSES));
  assign mac_en = en && (state == ACC) && !done;
  assign accept = en && (state == IDLE) && z_vld;
  assign z_rdy  = en && (state == IDLE);
  assign z_cur  = z_q[int'(row)*DW +: DW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int            col;
    int            widx;
    logic          lmask;
    logic [DW-1:0] lw;

    assign col   = int'(pass) * LANES + l;
    assign lmask = (col >= DIM);
    assign widx  = lmask ? 0 : int'(row) * DIM + col;
    assign lw    = w_q[widx*DW +: DW];

    est_mac_lane #(
      .DW    (DW),
      .AW    (AW),
      .PASSES(PASSES),
      .PW    (PW)
    ) u_lane (
      .clk (clk),
      .rstn(rstn),
      .en  (mac_en),
      .clr (accept),
      .mask(lmask),
      .sel (pass),
      .w   (lw),
      .z   (z_cur),
      .acc (acc_flat[l])
    );
  end

  // column j lives in lane j%LANES, slot j/LANES
  for (genvar j = 0; j < DIM; j++) begin : g_col
    localparam int LN = j % LANES;
    localparam int SL = j / LANES;
    logic signed [AW-1:0] acc;
    logic signed [AW:0]   biased;

    assign acc = acc_flat[LN][SL*AW +: AW];
`ifdef EST_ROUND_EN
    assign biased = (AW+1)'(acc) + (AW+1)'(BIAS);
`else
    assign biased = (AW+1)'(acc);
`endif
    assign scaled[j]  = 64'(biased >>> FRAC_BITS);
    assign clamped[j] = sat_clamp(scaled[j], DW);
  end

  always_comb begin
    s_nxt   = '0;
    sat_nxt = 1'b0;
    for (int j = 0; j < DIM; j++) begin
      s_nxt[j*DW +: DW] = clamped[j][DW-1:0];
      sat_nxt = sat_nxt | (clamped[j] != scaled[j]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      w_q        <= '0;
      z_q        <= '0;
      row        <= '0;
      pass       <= '0;
      s_vld      <= 1'b0;
      s_out      <= '0;
      sat_flag   <= 1'b0;
      sample_cnt <= '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (w_load) w_q <= w_in;
          if (z_vld) begin
            z_q   <= z_in;
            row   <= '0;
            pass  <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (done) begin
            s_out    <= s_nxt;
            sat_flag <= sat_nxt;
            s_vld    <= 1'b1;
            state    <= OUT;
          end else if (row == RW'(DIM - 1)) begin
            row  <= '0;
            pass <= pass + PW'(1);
          end else begin
            row <= row + RW'(1);
          end
        end
        OUT: begin
          if (s_rdy) begin
            s_vld      <= 1'b0;
            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_est_stream_mac.sv
// Bench for est_stream_mac: three configurations against a transaction model.
// Instances: LANES 3/1/2, FRAC_BITS 8/8/0, CNT_WIDTH 16/2/16.
module tb_est_stream_mac;

  localparam int DW  = 16;
  localparam int DIM = 3;

`ifdef EST_ROUND_EN
  localparam int S0A = 139;
`else
  localparam int S0A = 138;
`endif

  logic clk;
  logic rstn;
  logic en [3];
  logic w_load [3];
  logic z_vld [3];
  logic z_rdy [3];
  logic s_vld [3];
  logic s_rdy [3];
  logic sat [3];
  logic [DW*DIM*DIM-1:0] w_in [3];
  logic [DW*DIM-1:0] z_in [3];
  logic [DW*DIM-1:0] s_out [3];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [15:0] cnt2;

  int checks = 0;
  int failures = 0;

  longint mw [3][DIM][DIM];
  int mst [3];
  int rem [3];
  int ecnt [3];
  logic [DW*DIM-1:0] es [3];
  logic esat [3];
  int lat [3];

  est_stream_mac #(.DATA_WIDTH(16), .DIM(3), .LANES(3),
    .FRAC_BITS(8), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rstn(rstn), .en(en[0]), .w_load(w_load[0]),
    .w_in(w_in[0]), .z_vld(z_vld[0]), .z_rdy(z_rdy[0]),
    .z_in(z_in[0]), .s_vld(s_vld[0]), .s_rdy(s_rdy[0]),
    .s_out(s_out[0]), .sat_flag(sat[0]), .sample_cnt(cnt0));

  est_stream_mac #(.DATA_WIDTH(16), .DIM(3), .LANES(1),
    .FRAC_BITS(8), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rstn(rstn), .en(en[1]), .w_load(w_load[1]),
    .w_in(w_in[1]), .z_vld(z_vld[1]), .z_rdy(z_rdy[1]),
    .z_in(z_in[1]), .s_vld(s_vld[1]), .s_rdy(s_rdy[1]),
    .s_out(s_out[1]), .sat_flag(sat[1]), .sample_cnt(cnt1));

  est_stream_mac #(.DATA_WIDTH(16), .DIM(3), .LANES(2),
    .FRAC_BITS(0), .CNT_WIDTH(16)) u2 (
    .clk(clk), .rstn(rstn), .en(en[2]), .w_load(w_load[2]),
    .w_in(w_in[2]), .z_vld(z_vld[2]), .z_rdy(z_rdy[2]),
    .z_in(z_in[2]), .s_vld(s_vld[2]), .s_rdy(s_rdy[2]),
    .s_out(s_out[2]), .sat_flag(sat[2]), .sample_cnt(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lanes_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic int frac_of(input int k);
    return (k == 2) ? 0 : 8;
  endfunction

  function automatic int cw_of(input int k);
    return (k == 1) ? 2 : 16;
  endfunction

  function automatic int lat_of(input int k);
    int l;
    l = lanes_of(k);
    return DIM * ((DIM + l - 1) / l) + 1;
  endfunction

  function automatic longint cnt_of(input int k);
    if (k == 0) return longint'(cnt0);
    if (k == 1) return longint'(cnt1);
    return longint'(cnt2);
  endfunction

  function automatic logic [DW*DIM*DIM-1:0] pack_w(input int m [9]);
    logic [DW*DIM*DIM-1:0] v;
    v = '0;
    for (int e = 0; e < 9; e++) v[e*DW +: DW] = 16'(m[e]);
    return v;
  endfunction

  function automatic logic [DW*DIM-1:0] pack_z(input int a, input int b,
                                              input int c);
    logic [DW*DIM-1:0] v;
    v[0 +: DW]    = 16'(a);
    v[DW +: DW]   = 16'(b);
    v[2*DW +: DW] = 16'(c);
    return v;
  endfunction

  function automatic logic [15:0] rv();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 600)) - 300);
  endfunction

  task automatic chk(input string nm, input int k, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d exp=%0d t=%0t",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    mst[k]  = 0;
    rem[k]  = 0;
    ecnt[k] = 0;
    es[k]   = '0;
    esat[k] = 1'b0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) mw[k][i][j] = 0;
  endtask

  // S[j] = sum_i W[i][j]*Z[i], rescaled and clamped to 16 bits
  task automatic compute(input int k, input logic [DW*DIM-1:0] z);
    longint a;
    int f;
    f = frac_of(k);
    esat[k] = 1'b0;
    for (int j = 0; j < DIM; j++) begin
      a = 0;
      for (int i = 0; i < DIM; i++)
        a += mw[k][i][j] * longint'($signed(z[i*DW +: DW]));
`ifdef EST_ROUND_EN
      if (f > 0) a += longint'(1) << (f - 1);
`endif
      a = a >>> f;
      if (a > 32767) begin
        a = 32767;
        esat[k] = 1'b1;
      end else if (a < -32768) begin
        a = -32768;
        esat[k] = 1'b1;
      end
      es[k][j*DW +: DW] = 16'(a);
    end
  endtask

  task automatic advance(input int k);
    if (!en[k]) return;
    case (mst[k])
      0: begin
        if (w_load[k])
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
              mw[k][i][j] =
                longint'($signed(w_in[k][(i*DIM+j)*DW +: DW]));
        if (z_vld[k]) begin
          compute(k, z_in[k]);
          mst[k] = 1;
          rem[k] = lat_of(k);
        end
      end
      1: begin
        rem[k]--;
        if (rem[k] == 0) mst[k] = 2;
      end
      default: begin
        if (s_rdy[k]) begin
          mst[k]  = 0;
          ecnt[k] = (ecnt[k] + 1) % (1 << cw_of(k));
        end
      end
    endcase
  endtask

  // inputs are set at a negedge; one clock edge passes inside
  task automatic cycle();
    #1;
    if (!rstn) for (int k = 0; k < 3; k++) model_reset(k);
    for (int k = 0; k < 3; k++)
      chk("z_rdy", k, longint'(z_rdy[k]),
          longint'(en[k] && mst[k] == 0));
    if (rstn) for (int k = 0; k < 3; k++) advance(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("s_vld", k, longint'(s_vld[k]), longint'(mst[k] == 2));
      if (mst[k] == 2) begin
        chk("s_out", k, longint'(s_out[k]), longint'(es[k]));
        chk("sat_flag", k, longint'(sat[k]), longint'(esat[k]));
      end
      chk("sample_cnt", k, cnt_of(k), longint'(ecnt[k]));
    end
  endtask

  task automatic measure(input bit stall);
    for (int k = 0; k < 3; k++) lat[k] = 0;
    for (int t = 1; t <= 40; t++) begin
      for (int k = 0; k < 3; k++) begin
        z_vld[k]  = 1'b0;
        w_load[k] = stall && (t == 1);
        en[k]     = !(stall && t >= 2 && t <= 4);
        if (w_load[k])
          for (int e = 0; e < 9; e++) w_in[k][e*DW +: DW] = rv();
      end
      cycle();
      for (int k = 0; k < 3; k++)
        if (lat[k] == 0 && s_vld[k]) lat[k] = t;
    end
  endtask

  task automatic check_lits();
    for (int k = 0; k < 2; k++) begin
      chk("s0_lit", k, longint'($signed(s_out[k][15:0])), S0A);
      chk("sat_lit", k, longint'(sat[k]), 0);
    end
    chk("s0_sat", 2, longint'($signed(s_out[2][15:0])), 32767);
    chk("s1_sat", 2, longint'($signed(s_out[2][31:16])), -32768);
    chk("s2_lit", 2, longint'($signed(s_out[2][47:32])), 600);
    chk("sat_lit", 2, longint'(sat[2]), 1);
  endtask

  int wa [9] = '{120, -120, 0, 50, 50, 0, 80, -80, 0};
  int wb [9] = '{300, -300, 1, 200, -200, 2, 100, -100, 3};
  int seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    int n;
    longint prev;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k] = 0; w_load[k] = 0; z_vld[k] = 0; s_rdy[k] = 0;
      w_in[k] = '0; z_in[k] = '0;
      model_reset(k);
    end
    repeat (3) cycle();
    for (int k = 0; k < 3; k++) begin
      chk("rst_s_vld", k, longint'(s_vld[k]), 0);
      chk("rst_s_out", k, longint'(s_out[k]), 0);
      chk("rst_sat", k, longint'(sat[k]), 0);
      chk("rst_cnt", k, cnt_of(k), 0);
      chk("rst_z_rdy", k, longint'(z_rdy[k]), 0);
    end
    rstn = 1'b1;
    cycle();

    for (int k = 0; k < 3; k++) begin
      en[k]     = 1;
      w_load[k] = 1;
      w_in[k]   = (k < 2) ? pack_w(wa) : pack_w(wb);
      z_vld[k]  = 1;
      z_in[k]   = (k < 2) ? pack_z(100, 150, 200) : pack_z(100, 100, 100);
    end
    cycle();
    measure(1'b0);
    chk("lat", 0, lat[0], 4);
    chk("lat", 1, lat[1], 10);
    chk("lat", 2, lat[2], 7);
    check_lits();
    for (int k = 0; k < 3; k++) begin
      chk("cnt_hold", k, cnt_of(k), 0);
      s_rdy[k] = 1;
    end
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("cnt_hs", k, cnt_of(k), 1);
      s_rdy[k] = 0;
      z_vld[k] = 1;
    end
    cycle();
    measure(1'b1);
    chk("lat_stall", 0, lat[0], 7);
    chk("lat_stall", 1, lat[1], 13);
    chk("lat_stall", 2, lat[2], 10);
    check_lits();
    for (int k = 0; k < 3; k++) s_rdy[k] = 1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      s_rdy[k] = 0;
      z_vld[k] = 1;
    end
    cycle();
    for (int k = 0; k < 3; k++) z_vld[k] = 0;
    cycle();
    rstn = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_vld", k, longint'(s_vld[k]), 0);
      chk("rst_mid_cnt", k, cnt_of(k), 0);
    end
    rstn = 1'b1;
    cycle();

    for (int k = 0; k < 3; k++) begin
      z_vld[k] = 1;
      s_rdy[k] = 1;
      z_in[k]  = pack_z(7, -9, 11);
    end
    n = 0;
    prev = cnt_of(1);
    for (int t = 0; t < 100 && n < 5; t++) begin
      cycle();
      if (cnt_of(1) != prev) begin
        chk("cnt_seq", 1, cnt_of(1), seq[n]);
        prev = cnt_of(1);
        n++;
      end
    end
    chk("cnt_seq_done", 1, n, 5);

    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < 3; k++) begin
        en[k]     = ($urandom_range(0, 9) != 0);
        z_vld[k]  = ($urandom_range(0, 1) == 1);
        s_rdy[k]  = ($urandom_range(0, 4) < 3);
        w_load[k] = ($urandom_range(0, 4) == 0);
        for (int e = 0; e < 9; e++) w_in[k][e*DW +: DW] = rv();
        for (int e = 0; e < 3; e++) z_in[k][e*DW +: DW] = rv();
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
